// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA256 wrapper: FSM states, load phases,
// RS232 IP register map and status bit positions.
package rsa_pkg;

  typedef enum logic [2:0] {
    S_QUERY_RX,
    S_READ_RX,
    S_START,
    S_WAIT,
    S_QUERY_TX,
    S_WRITE_TX
  } state_t;

  typedef enum logic [1:0] {
    PH_N,
    PH_D,
    PH_A
  } phase_t;

  localparam logic [4:0] RX_BASE     = 5'd0;
  localparam logic [4:0] TX_BASE     = 5'd4;
  localparam logic [4:0] STATUS_BASE = 5'd8;

  localparam int unsigned RX_OK_BIT = 7;
  localparam int unsigned TX_OK_BIT = 6;

  localparam int unsigned KEY_BYTES = 32;
  localparam int unsigned TX_BYTES  = 31;

endpackage

// File: rtl/rsa256_wrapper_if.sv
// Avalon-MM link between the RSA256 wrapper (master) and the RS232 IP (slave).
interface rsa256_wrapper_if;

  logic [4:0]  avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata,
    output avm_readdata, avm_waitrequest
  );

endinterface

// File: rtl/rsa256_wrapper.sv
// Streams key and ciphertext bytes from the RS232 IP into the RSA core, then sends
// the 31 low result bytes back; n and d are kept across blocks until reset.
module rsa256_wrapper
  import rsa_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  rsa256_wrapper_if.master      avm,
  output logic                  o_core_start,
  output logic [255:0]          o_core_n,
  output logic [255:0]          o_core_d,
  output logic [255:0]          o_core_a,
  input  logic [255:0]          i_core_a_pow_d,
  input  logic                  i_core_finished
);

  state_t       state_q;
  phase_t       phase_q;
  logic [5:0]   cnt_q;
  logic [255:0] n_q, d_q, a_q, out_q;
  logic         read_q, write_q, start_q;
  logic [4:0]   addr_q;
  logic [31:0]  wdata_q;

  logic [7:0]   rx_byte;
  logic         xfer_done;

  assign rx_byte   = avm.avm_readdata[7:0];
  assign xfer_done = (read_q | write_q) & ~avm.avm_waitrequest;

  // Each transfer is issued in one cycle and retired on the first cycle without
  // waitrequest; the request drops for a cycle before the next one is issued.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_QUERY_RX;
      phase_q <= PH_N;
      cnt_q   <= '0;
      n_q     <= '0;
      d_q     <= '0;
      a_q     <= '0;
      out_q   <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      start_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        S_QUERY_RX: begin
          if (!read_q) begin
            read_q <= 1'b1;
            addr_q <= STATUS_BASE;
          end else if (xfer_done) begin
            read_q <= 1'b0;
            if (avm.avm_readdata[RX_OK_BIT]) state_q <= S_READ_RX;
          end
        end
        S_READ_RX: begin
          if (!read_q) begin
            read_q <= 1'b1;
            addr_q <= RX_BASE;
          end else if (xfer_done) begin
            read_q <= 1'b0;
            unique case (phase_q)
              PH_N:    n_q <= {n_q[247:0], rx_byte};
              PH_D:    d_q <= {d_q[247:0], rx_byte};
              default: a_q <= {a_q[247:0], rx_byte};
            endcase
            if (cnt_q == 6'(KEY_BYTES - 1)) begin
              cnt_q <= '0;
              unique case (phase_q)
                PH_N: begin
                  phase_q <= PH_D;
                  state_q <= S_QUERY_RX;
                end
                PH_D: begin
                  phase_q <= PH_A;
                  state_q <= S_QUERY_RX;
                end
                default: state_q <= S_START;
              endcase
            end else begin
              cnt_q   <= cnt_q + 6'd1;
              state_q <= S_QUERY_RX;
            end
          end
        end
        S_START: begin
          start_q <= 1'b1;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (i_core_finished) begin
            out_q   <= i_core_a_pow_d;
            state_q <= S_QUERY_TX;
          end
        end
        S_QUERY_TX: begin
          if (!read_q) begin
            read_q <= 1'b1;
            addr_q <= STATUS_BASE;
          end else if (xfer_done) begin
            read_q <= 1'b0;
            if (avm.avm_readdata[TX_OK_BIT]) state_q <= S_WRITE_TX;
          end
        end
        S_WRITE_TX: begin
          if (!write_q) begin
            write_q <= 1'b1;
            addr_q  <= TX_BASE;
            wdata_q <= {24'b0, out_q[247:240]};
          end else if (xfer_done) begin
            write_q <= 1'b0;
            out_q   <= out_q << 8;
            if (cnt_q == 6'(TX_BYTES - 1)) begin
              cnt_q   <= '0;
              state_q <= S_QUERY_RX;
            end else begin
              cnt_q   <= cnt_q + 6'd1;
              state_q <= S_QUERY_TX;
            end
          end
        end
        default: state_q <= S_QUERY_RX;
      endcase
    end
  end

  assign avm.avm_address   = addr_q;
  assign avm.avm_read      = read_q;
  assign avm.avm_write     = write_q;
  assign avm.avm_writedata = wdata_q;

  assign o_core_start = start_q;
  assign o_core_n     = n_q;
  assign o_core_d     = d_q;
  assign o_core_a     = a_q;

endmodule

// File: tb/tb_rsa256_wrapper.sv
// Bench for rsa256_wrapper: Avalon RS232 slave model, stub RSA core and per-scenario tasks.
module tb_rsa256_wrapper;
  import rsa_pkg::*;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         core_start;
  logic [255:0] core_n, core_d, core_a;
  logic [255:0] core_res = '0;
  logic [255:0] core_res_next = '0;
  logic         stub_fin = 1'b0;
  logic         spur_fin = 1'b0;
  logic         core_fin;

  rsa256_wrapper_if avm ();

  rsa256_wrapper dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .avm             (avm),
    .o_core_start    (core_start),
    .o_core_n        (core_n),
    .o_core_d        (core_d),
    .o_core_a        (core_a),
    .i_core_a_pow_d  (core_res),
    .i_core_finished (core_fin)
  );

  assign core_fin = stub_fin | spur_fin;

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass = 0;

  // Slave model state
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  int status_polls = 0, rx_reads = 0, polls_at_rx = 0, proto_err = 0;
  int stall_err = 0, stall_cycles = 0, low_until = 0;
  int stall_rx_index = 0, stall_done_idx = 0, wait_cnt = 0;
  logic stalled = 1'b0;
  logic [4:0] stall_addr = '0;
  logic rx_ok;

  // Stub core / monitor state
  int start_cnt = 0, rx_at_start = 0, core_cnt = 0, a_change_err = 0;
  logic [255:0] core_a_seen = '0;

  logic [255:0] key_n, key_d, model_a;

  // Slave decides each request's response on the falling edge; it retires on the next rise.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      avm.avm_waitrequest = 1'b0;
      avm.avm_readdata    = '0;
      stalled  = 1'b0;
      wait_cnt = 0;
    end else begin
      if (avm.avm_read && avm.avm_write) proto_err++;
      if (stalled && (!(avm.avm_read || avm.avm_write) || avm.avm_address != stall_addr))
        stall_err++;
      stalled = 1'b0;
      if (avm.avm_read || avm.avm_write) begin
        if (avm.avm_read && avm.avm_address == RX_BASE && rx_reads + 1 == stall_rx_index &&
            stall_done_idx != stall_rx_index) begin
          wait_cnt       = 3;
          stall_done_idx = stall_rx_index;
        end
        if (wait_cnt > 0) begin
          wait_cnt--;
          stall_cycles++;
          avm.avm_waitrequest = 1'b1;
          stalled    = 1'b1;
          stall_addr = avm.avm_address;
        end else begin
          avm.avm_waitrequest = 1'b0;
          if (avm.avm_read && avm.avm_address == STATUS_BASE) begin
            status_polls++;
            rx_ok = (status_polls > low_until) && (rx_q.size() > 0);
            avm.avm_readdata = {24'b0, rx_ok, 1'b1, 6'b0};
          end else if (avm.avm_read && avm.avm_address == RX_BASE) begin
            rx_reads++;
            polls_at_rx = status_polls;
            if (rx_q.size() > 0) avm.avm_readdata = {24'b0, rx_q.pop_front()};
            else begin
              proto_err++;
              avm.avm_readdata = '0;
            end
          end else if (avm.avm_write && avm.avm_address == TX_BASE) begin
            tx_q.push_back(avm.avm_writedata[7:0]);
            if (avm.avm_writedata[31:8] != 24'b0) proto_err++;
          end else proto_err++;
        end
      end else avm.avm_waitrequest = 1'b0;
    end
  end

  // Stub core: answers core_res_next ten cycles after each start pulse.
  always @(negedge i_clk) begin
    stub_fin = 1'b0;
    if (!i_rst_n) core_cnt = 0;
    else if (core_start) begin
      start_cnt++;
      rx_at_start = rx_reads;
      core_a_seen = core_a;
      core_cnt    = 10;
    end else if (core_cnt > 0) begin
      if (core_a !== core_a_seen) a_change_err++;
      core_cnt--;
      if (core_cnt == 0) begin
        core_res = core_res_next;
        stub_fin = 1'b1;
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(posedge i_clk);
    #1;
  endtask

  task automatic wait_rx(input int target, input string name);
    for (int c = 0; c < 4000 && rx_reads < target; c++) tick(1);
    n_checks++;
    if (rx_reads < target) $display("FAIL %s timeout: rx reads %0d, need %0d", name, rx_reads, target);
    else n_pass++;
  endtask

  task automatic wait_tx(input int target, input string name);
    for (int c = 0; c < 4000 && tx_q.size() < target; c++) tick(1);
    n_checks++;
    if (tx_q.size() < target)
      $display("FAIL %s timeout: tx bytes %0d, need %0d", name, tx_q.size(), target);
    else n_pass++;
  endtask

  task automatic push_key(output logic [255:0] kn, output logic [255:0] kd, input bit fixed);
    logic [7:0] b;
    kn = '0;
    kd = '0;
    for (int i = 0; i < 32; i++) begin
      b = fixed ? 8'(i + 1) : 8'($urandom);
      kn[255 - 8*i -: 8] = b;
      rx_q.push_back(b);
    end
    for (int i = 0; i < 32; i++) begin
      b = fixed ? 8'(255 - i) : 8'($urandom);
      kd[255 - 8*i -: 8] = b;
      rx_q.push_back(b);
    end
  endtask

  task automatic check_tx(input logic [255:0] res, input string name);
    logic [7:0] exp;
    for (int k = 0; k < 31; k++) begin
      exp = res[247 - 8*k -: 8];
      n_checks++;
      if (k >= tx_q.size() || tx_q[k] !== exp)
        $display("FAIL %s byte %0d: got %h, expected %h", name, k,
                 (k < tx_q.size()) ? tx_q[k] : 8'hxx, exp);
      else n_pass++;
    end
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0;
    tick(3);
    n_checks++;
    if ({avm.avm_read, avm.avm_write, avm.avm_address, avm.avm_writedata} !== '0)
      $display("FAIL reset_bus: rd=%b wr=%b addr=%h wdata=%h, expected all 0", avm.avm_read,
               avm.avm_write, avm.avm_address, avm.avm_writedata);
    else n_pass++;
    n_checks++;
    if ({core_start, core_n, core_d, core_a} !== '0)
      $display("FAIL reset_core: start=%b n=%h d=%h a=%h, expected all 0", core_start, core_n,
               core_d, core_a);
    else n_pass++;
    i_rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_key_load(input bit fixed, input string name);
    int r0, s0;
    r0 = rx_reads;
    s0 = start_cnt;
    push_key(key_n, key_d, fixed);
    wait_rx(r0 + 64, name);
    tick(6);
    n_checks++;
    if (core_n !== key_n) $display("FAIL %s n: got %h, expected %h", name, core_n, key_n);
    else n_pass++;
    n_checks++;
    if (core_d !== key_d) $display("FAIL %s d: got %h, expected %h", name, core_d, key_d);
    else n_pass++;
    n_checks++;
    if (start_cnt != s0) $display("FAIL %s no_start: got %0d pulses, expected 0", name, start_cnt - s0);
    else n_pass++;
  endtask

  task automatic test_polling;
    int p0, r0;
    p0 = status_polls;
    r0 = rx_reads;
    low_until = p0 + 5;
    rx_q.push_back(8'hA5);
    wait_rx(r0 + 1, "polling");
    tick(4);
    n_checks++;
    if (polls_at_rx - p0 != 6)
      $display("FAIL polling: first RX read after %0d polls, expected 6", polls_at_rx - p0);
    else n_pass++;
  endtask

  task automatic test_stall;
    int r0, c0, e0;
    r0 = rx_reads;
    c0 = stall_cycles;
    e0 = stall_err;
    stall_rx_index = rx_reads + 1;
    rx_q.push_back(8'hA5);
    wait_rx(r0 + 1, "stall");
    tick(4);
    n_checks++;
    if (stall_cycles - c0 != 3 || stall_err != e0)
      $display("FAIL stall_hold: stall cycles %0d unstable %0d, expected 3 and 0",
               stall_cycles - c0, stall_err - e0);
    else n_pass++;
    n_checks++;
    if (core_a !== 256'hA5A5 || rx_reads - r0 != 1)
      $display("FAIL stall_capture: a=%h reads=%0d, expected a=a5a5 reads=1", core_a,
               rx_reads - r0);
    else n_pass++;
  endtask

  task automatic test_full_block(input int r_block);
    int s0;
    s0 = start_cnt;
    model_a = {32{8'hA5}};
    for (int k = 0; k < 32; k++) core_res_next[255 - 8*k -: 8] = (k == 0) ? 8'h00 : 8'(k * 17);
    tx_q.delete();
    for (int k = 0; k < 30; k++) rx_q.push_back(8'hA5);
    wait_tx(31, "full_block");
    tick(40);
    n_checks++;
    if (start_cnt - s0 != 1 || rx_at_start - r_block != 32)
      $display("FAIL full_start: pulses %0d after %0d bytes, expected 1 after 32",
               start_cnt - s0, rx_at_start - r_block);
    else n_pass++;
    n_checks++;
    if (core_a_seen !== model_a || a_change_err != 0)
      $display("FAIL full_a: a=%h changes=%0d, expected %h and 0", core_a_seen, a_change_err,
               model_a);
    else n_pass++;
    n_checks++;
    if (tx_q.size() != 31) $display("FAIL full_tx_count: got %0d, expected 31", tx_q.size());
    else n_pass++;
    check_tx(core_res_next, "full_tx");
  endtask

  task automatic test_key_reuse;
    int r0, s0;
    tx_q.delete();
    // A finish pulse outside S_WAIT must not trigger any transmission.
    spur_fin = 1'b1;
    tick(1);
    spur_fin = 1'b0;
    tick(30);
    n_checks++;
    if (tx_q.size() != 0) $display("FAIL spurious_finish: got %0d tx bytes, expected 0", tx_q.size());
    else n_pass++;
    r0 = rx_reads;
    s0 = start_cnt;
    for (int k = 0; k < 32; k++) begin
      model_a[255 - 8*k -: 8] = 8'($urandom);
      core_res_next[255 - 8*k -: 8] = 8'($urandom);
      rx_q.push_back(model_a[255 - 8*k -: 8]);
    end
    wait_tx(31, "reuse");
    tick(40);
    n_checks++;
    if (start_cnt - s0 != 1 || rx_at_start - r0 != 32)
      $display("FAIL reuse_start: pulses %0d after %0d bytes, expected 1 after 32",
               start_cnt - s0, rx_at_start - r0);
    else n_pass++;
    n_checks++;
    if (core_n !== key_n || core_d !== key_d || core_a_seen !== model_a)
      $display("FAIL reuse_regs: n=%h d=%h a=%h, expected n=%h d=%h a=%h", core_n, core_d,
               core_a_seen, key_n, key_d, model_a);
    else n_pass++;
    check_tx(core_res_next, "reuse_tx");
  endtask

  task automatic test_reset_mid_send;
    for (int k = 0; k < 32; k++) begin
      core_res_next[255 - 8*k -: 8] = 8'($urandom);
      rx_q.push_back(8'($urandom));
    end
    tx_q.delete();
    wait_tx(10, "mid_send");
    i_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({avm.avm_read, avm.avm_write, avm.avm_address, avm.avm_writedata, core_start, core_n,
         core_d, core_a} !== '0)
      $display("FAIL mid_reset_outputs: rd=%b wr=%b addr=%h wdata=%h start=%b n=%h d=%h a=%h, expected all 0",
               avm.avm_read, avm.avm_write, avm.avm_address, avm.avm_writedata, core_start,
               core_n, core_d, core_a);
    else n_pass++;
    rx_q.delete();
    tx_q.delete();
    tick(2);
    i_rst_n = 1'b1;
    tick(2);
    test_key_load(1'b0, "reload");
    n_checks++;
    if (tx_q.size() != 0) $display("FAIL reload_tx: got %0d tx bytes, expected 0", tx_q.size());
    else n_pass++;
  endtask

  initial begin
    int r_block;
    test_reset();
    test_key_load(1'b1, "key_load");
    r_block = rx_reads;
    test_polling();
    test_stall();
    test_full_block(r_block);
    test_key_reuse();
    test_reset_mid_send();
    n_checks++;
    if (proto_err != 0) $display("FAIL bus_protocol: %0d violations, expected 0", proto_err);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
